// File: rtl/uart_tx_arb.sv
// Shares the simpleuart transmit data port among NREQ requesters. A requester
// keeps the UART for a whole message; messages are served round-robin.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                bus_clk,
  input  logic                bus_reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     grant,
  output logic                busy,
  output logic                uart_we,
  output logic [31:0]         uart_di,
  input  logic                uart_ack
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] OWNER_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   owner_r, owner_s;
  logic [IW-1:0]   last_owner_r, last_owner_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [7:0]      byte_r, byte_s;
  logic            last_r, last_s;
  logic [CW-1:0]   idle_cnt_r, idle_cnt_s;
  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [IW-1:0]   cand_s;
  logic [7:0]      req_byte_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_byte
    assign req_byte_s[g] = req_data[8*g +: 8];
  end

  // Round-robin scan starting just after the owner of the previous message.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = last_owner_r;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_owner_r) + k) % NREQ);
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic: message lock, byte latch and idle-lock timeout.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_owner_s = last_owner_r;
    grant_s      = grant_r;
    byte_s       = byte_r;
    last_s       = last_r;
    idle_cnt_s   = idle_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          owner_s = win_idx_s;
          grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
          byte_s  = req_byte_s[win_idx_s];
          last_s  = req_last[win_idx_s];
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (uart_ack && last_r) begin
          last_owner_s = owner_r;
          grant_s      = '0;
          state_s      = ST_IDLE;
        end else if (uart_ack) begin
          idle_cnt_s = '0;
          state_s    = ST_HOLD;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_HOLD: begin
        // A byte arriving on the timeout cycle keeps the lock.
        if (req_valid[owner_r]) begin
          byte_s  = req_byte_s[owner_r];
          last_s  = req_last[owner_r];
          state_s = ST_SEND;
        end else if ((TIMEOUT != 0) && (idle_cnt_r == CNT_LAST)) begin
          last_owner_s = owner_r;
          grant_s      = '0;
          state_s      = ST_IDLE;
        end else begin
          idle_cnt_s = idle_cnt_r + CW'(1);
        end
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= '0;
      last_owner_r <= OWNER_RST;
      grant_r      <= '0;
      byte_r       <= 8'h00;
      last_r       <= 1'b0;
      idle_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_owner_r <= last_owner_s;
      grant_r      <= grant_s;
      byte_r       <= byte_s;
      last_r       <= last_s;
      idle_cnt_r   <= idle_cnt_s;
    end
  end

  assign grant     = grant_r;
  assign busy      = (state_r != ST_IDLE);
  assign uart_we   = (state_r == ST_SEND);
  assign uart_di   = (state_r == ST_SEND) ? {24'd0, byte_r} : 32'd0;
  assign req_ready = ((state_r == ST_SEND) && uart_ack && !bus_reset) ? grant_r : '0;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized message traffic
// checked against a message-level round-robin reference model.
module tb_uart_tx_arb;

  logic        bus_clk;
  logic        bus_reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        uart_we;
  logic [31:0] uart_di;
  logic        uart_ack;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] rq [4][$];
  logic [8:0] mq [4][$];
  int         obs_o[$], obs_b[$], obs_c[$];
  int         exp_o[$], exp_b[$];
  logic [3:0] gtrace[$];
  int         inv_bad;
  bit         timed_out;

  uart_tx_arb #(.NREQ(4), .TIMEOUT(16)) dut (
    .bus_clk   (bus_clk),
    .bus_reset (bus_reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .uart_we   (uart_we),
    .uart_di   (uart_di),
    .uart_ack  (uart_ack)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  function automatic int oh2idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    bus_reset = 1'b1; req_valid = 4'h0; req_last = 4'h0; req_data = 32'h0; uart_ack = 1'b0;
    step();
    step();
    bus_reset = 1'b0;
  endtask

  // Plays the message queues in rq under the requester rules and records UART writes.
  task automatic run_traffic(input int max_cycles, input int ack_max);
    logic [3:0] rdy_prev = 4'h0;
    logic [3:0] gap = 4'h0;
    logic [3:0] gprev = 4'h0;
    bit in_send = 1'b0;
    int wait_n = 0;
    bit all_empty;
    obs_o.delete(); obs_b.delete(); obs_c.delete(); gtrace.delete();
    inv_bad = 0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      step();
      all_empty = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (rdy_prev[i]) begin
          void'(rq[i].pop_front());
          gap[i] = 1'b1;
        end
        if (rq[i].size() > 0) all_empty = 1'b0;
      end
      if (all_empty) begin
        timed_out = 1'b0;
        break;
      end
      for (int i = 0; i < 4; i++) begin
        if (gap[i]) begin
          req_valid[i] = 1'b0;
          gap[i] = 1'b0;
        end else if (rq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if (uart_we) begin
        if (!in_send) begin
          in_send = 1'b1;
          wait_n = $urandom_range(0, ack_max);
        end
        uart_ack = (wait_n == 0);
        if (wait_n > 0) wait_n--;
      end else begin
        in_send = 1'b0;
        uart_ack = 1'($urandom_range(0, 1));
      end
      @(negedge bus_clk);
      rdy_prev = req_ready;
      if (req_ready != 4'h0) begin
        obs_o.push_back(oh2idx(req_ready));
        obs_b.push_back(int'(uart_di[7:0]));
        obs_c.push_back(cyc);
        if (req_ready !== grant || !uart_we || uart_di[31:8] !== 24'd0) inv_bad++;
      end
      if (grant != 4'h0 && oh2idx(grant) < 0) inv_bad++;
      if ((grant & (grant - 4'h1)) != 4'h0) inv_bad++;
      if (grant !== gprev) gtrace.push_back(grant);
      gprev = grant;
    end
    req_valid = 4'h0; req_last = 4'h0; uart_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    bus_reset = 1'b1; req_valid = 4'hF; req_last = 4'hF; req_data = 32'h11223344; uart_ack = 1'b1;
    step();
    @(negedge bus_clk);
    n_vec++;
    if ({grant, busy, uart_we, req_ready} !== 10'd0 || uart_di !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b busy=%b we=%b ready=%b di=%h, required all zero",
               grant, busy, uart_we, req_ready, uart_di);
    end
    step();
    bus_reset = 1'b0; req_valid = 4'h0; req_last = 4'h0; uart_ack = 1'b0;
    @(negedge bus_clk);
    n_vec++;
    if (grant !== 4'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: grant=%b busy=%b, required 0000/0", grant, busy);
    end
  endtask

  task automatic test_single();
    step();
    req_valid = 4'b0100; req_data[23:16] = 8'h41; req_last = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      step();
      uart_ack = (c == 4);
      @(negedge bus_clk);
      n_vec++;
      if (grant !== 4'b0100 || busy !== 1'b1 || uart_we !== 1'b1 || uart_di !== 32'h41 ||
          req_ready !== ((c == 4) ? 4'b0100 : 4'b0000)) begin
        n_err++;
        $display("FAIL single_c%0d: grant=%b busy=%b we=%b di=%h ready=%b, required 0100/1/1/41/%b",
                 c, grant, busy, uart_we, uart_di, req_ready, (c == 4) ? 4'b0100 : 4'b0000);
      end
    end
    step();
    req_valid = 4'h0; req_last = 4'h0; uart_ack = 1'b0;
    @(negedge bus_clk);
    n_vec++;
    if (grant !== 4'h0 || busy !== 1'b0 || uart_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: grant=%b busy=%b we=%b, required 0000/0/0", grant, busy, uart_we);
    end
  endtask

  task automatic test_locking();
    logic [3:0] exp_g [3] = '{4'b0001, 4'b0000, 4'b0010};
    int eo [3] = '{0, 0, 1};
    int eb [3] = '{32'h41, 32'h42, 32'h5A};
    rq[0] = '{9'h041, 9'h142};
    rq[1] = '{9'h15A};
    run_traffic(200, 3);
    n_vec++;
    if (timed_out || obs_o.size() != 3) begin
      n_err++;
      $display("FAIL lock_count: writes=%0d timed_out=%0d, required 3/0", obs_o.size(), timed_out);
    end
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (j >= obs_o.size() || obs_o[j] != eo[j] || obs_b[j] != eb[j]) begin
        n_err++;
        $display("FAIL lock_write%0d: owner=%0d byte=%h, required %0d/%h", j,
                 (j < obs_o.size()) ? obs_o[j] : -1, (j < obs_b.size()) ? obs_b[j] : -1, eo[j], eb[j]);
      end
      n_vec++;
      if (j >= gtrace.size() || gtrace[j] !== exp_g[j]) begin
        n_err++;
        $display("FAIL lock_grant%0d: grant=%b, required %b", j,
                 (j < gtrace.size()) ? gtrace[j] : 4'hx, exp_g[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    int eo [6] = '{0, 1, 2, 3, 0, 1};
    int eb [6];
    do_reset();
    for (int j = 0; j < 6; j++) eb[j] = $urandom_range(0, 255);
    for (int j = 0; j < 6; j++) rq[eo[j]].push_back({1'b1, 8'(eb[j])});
    run_traffic(200, 0);
    n_vec++;
    if (timed_out || obs_o.size() != 6 || inv_bad != 0) begin
      n_err++;
      $display("FAIL rr_count: writes=%0d timed_out=%0d inv=%0d, required 6/0/0", obs_o.size(), timed_out, inv_bad);
    end
    for (int j = 0; j < 6 && j < obs_o.size(); j++) begin
      n_vec++;
      if (obs_o[j] != eo[j] || obs_b[j] != eb[j]) begin
        n_err++;
        $display("FAIL rr_order%0d: owner=%0d byte=%h, required %0d/%h", j, obs_o[j], obs_b[j], eo[j], eb[j]);
      end
      if (j > 0) begin
        n_vec++;
        if (obs_c[j] - obs_c[j-1] != 2) begin
          n_err++;
          $display("FAIL rr_gap%0d: spacing=%0d cycles, required 2", j, obs_c[j] - obs_c[j-1]);
        end
      end
    end
    n_vec++;
    if (gtrace.size() < 2 || gtrace[1] !== 4'b0000) begin
      n_err++;
      $display("FAIL rr_idle: grant trace missing idle between owners, required 0000 after first grant");
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 20; c++) begin
      step();
      if (c == 0) begin req_valid = 4'b1000; req_data[31:24] = 8'h10; req_last = 4'b0000; end
      if (c == 1) uart_ack = 1'b1;
      if (c == 2) begin uart_ack = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'h77; req_last = 4'b0010; end
      if (c == 19) uart_ack = 1'b1;
      if (c == 20) begin uart_ack = 1'b0; req_valid = 4'h0; req_last = 4'h0; end
      @(negedge bus_clk);
      if (c >= 2 && c <= 17) begin
        n_vec++;
        if (grant !== 4'b1000 || busy !== 1'b1 || uart_we !== 1'b0) begin
          n_err++;
          $display("FAIL to_hold_c%0d: grant=%b busy=%b we=%b, required 1000/1/0", c, grant, busy, uart_we);
        end
      end
      if (c == 18) begin
        n_vec++;
        if (grant !== 4'h0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL to_release: grant=%b busy=%b, required 0000/0", grant, busy);
        end
      end
      if (c == 19) begin
        n_vec++;
        if (grant !== 4'b0010 || uart_di !== 32'h77 || req_ready !== 4'b0010) begin
          n_err++;
          $display("FAIL to_next: grant=%b di=%h ready=%b, required 0010/77/0010", grant, uart_di, req_ready);
        end
      end
    end
    for (int c = 0; c <= 19; c++) begin
      step();
      if (c == 0) begin req_valid = 4'b1000; req_data[31:24] = 8'h20; req_last = 4'b0000; end
      if (c == 1) uart_ack = 1'b1;
      if (c == 2) begin uart_ack = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'h55; req_last = 4'b0010; end
      if (c == 17) begin req_valid = 4'b1010; req_data[31:24] = 8'h21; req_last = 4'b1010; end
      if (c == 18) uart_ack = 1'b1;
      if (c == 19) begin uart_ack = 1'b0; req_valid = 4'h0; req_last = 4'h0; end
      @(negedge bus_clk);
      if (c == 18) begin
        n_vec++;
        if (grant !== 4'b1000 || uart_we !== 1'b1 || uart_di !== 32'h21 || req_ready !== 4'b1000) begin
          n_err++;
          $display("FAIL to_keep: grant=%b we=%b di=%h ready=%b, required 1000/1/21/1000",
                   grant, uart_we, uart_di, req_ready);
        end
      end
    end
  endtask

  task automatic test_stall();
    step();
    req_valid = 4'b0001; req_data[7:0] = 8'h33; req_last = 4'b0001;
    for (int c = 1; c <= 1002; c++) begin
      step();
      if (c == 500) req_data[7:0] = 8'hEE;
      if (c == 700) req_valid = 4'h0;
      uart_ack = (c == 1001);
      @(negedge bus_clk);
      if (c <= 1000) begin
        if (uart_we !== 1'b1 || uart_di !== 32'h33 || req_ready !== 4'h0) begin
          n_vec++; n_err++;
          $display("FAIL stall_c%0d: we=%b di=%h ready=%b, required 1/33/0000", c, uart_we, uart_di, req_ready);
        end else if (c % 100 == 0) begin
          n_vec++;
        end
      end
      if (c == 1001) begin
        n_vec++;
        if (req_ready !== 4'b0001 || uart_di !== 32'h33) begin
          n_err++;
          $display("FAIL stall_ack: ready=%b di=%h, required 0001/33", req_ready, uart_di);
        end
      end
      if (c == 1002) begin
        n_vec++;
        if (uart_we !== 1'b0 || grant !== 4'h0) begin
          n_err++;
          $display("FAIL stall_done: we=%b grant=%b, required 0/0000", uart_we, grant);
        end
      end
    end
    req_last = 4'h0; uart_ack = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    for (int c = 0; c <= 7; c++) begin
      step();
      if (c == 0) begin req_valid = 4'b0100; req_data[23:16] = 8'h99; req_last = 4'b0100; end
      if (c == 2) begin bus_reset = 1'b1; uart_ack = 1'b1; req_valid = 4'h0; end
      if (c == 3) begin
        bus_reset = 1'b0; uart_ack = 1'b0; req_valid = 4'b1001; req_last = 4'b1001;
        req_data[7:0] = 8'h01; req_data[31:24] = 8'h03;
      end
      if (c == 4) uart_ack = 1'b1;
      if (c == 5) begin uart_ack = 1'b0; req_valid = 4'b1000; end
      if (c == 6) uart_ack = 1'b1;
      if (c == 7) begin uart_ack = 1'b0; req_valid = 4'h0; req_last = 4'h0; end
      @(negedge bus_clk);
      if (c == 1 || c == 2) begin
        n_vec++;
        if (grant !== 4'b0100 || req_ready !== 4'h0) begin
          n_err++;
          $display("FAIL rst_send_c%0d: grant=%b ready=%b, required 0100/0000", c, grant, req_ready);
        end
      end
      if (c == 3) begin
        n_vec++;
        if ({grant, busy, uart_we, req_ready} !== 10'd0 || uart_di !== 32'd0) begin
          n_err++;
          $display("FAIL rst_values: grant=%b busy=%b we=%b ready=%b di=%h, required all zero",
                   grant, busy, uart_we, req_ready, uart_di);
        end
      end
      if (c == 4) begin
        n_vec++;
        if (grant !== 4'b0001 || uart_di !== 32'h01 || req_ready !== 4'b0001) begin
          n_err++;
          $display("FAIL rst_first: grant=%b di=%h ready=%b, required 0001/01/0001", grant, uart_di, req_ready);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (grant !== 4'b1000 || uart_di !== 32'h03) begin
          n_err++;
          $display("FAIL rst_second: grant=%b di=%h, required 1000/03", grant, uart_di);
        end
      end
    end
  endtask

  // Random messages; the model serves whole messages round-robin from last owner 3.
  task automatic test_random();
    int cur, c, nmsg, len;
    bit found, any;
    for (int round = 0; round < 3; round++) begin
      exp_o.delete(); exp_b.delete();
      for (int i = 0; i < 4; i++) begin
        rq[i].delete();
        nmsg = $urandom_range((i == 0) ? 1 : 0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
        end
        mq[i] = rq[i];
      end
      cur = 3;
      any = 1'b1;
      while (any) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          c = (cur + k) % 4;
          if (!found && mq[c].size() > 0) begin
            found = 1'b1;
            cur = c;
          end
        end
        any = found;
        if (found) begin
          while (mq[cur].size() > 0 && !mq[cur][0][8]) begin
            exp_o.push_back(cur); exp_b.push_back(int'(mq[cur][0][7:0])); void'(mq[cur].pop_front());
          end
          exp_o.push_back(cur); exp_b.push_back(int'(mq[cur][0][7:0])); void'(mq[cur].pop_front());
        end
      end
      do_reset();
      run_traffic(4000, 3);
      n_vec++;
      if (timed_out || obs_o.size() != exp_o.size() || inv_bad != 0) begin
        n_err++;
        $display("FAIL rand%0d_count: writes=%0d timed_out=%0d inv=%0d, required %0d/0/0",
                 round, obs_o.size(), timed_out, inv_bad, exp_o.size());
      end
      for (int j = 0; j < exp_o.size(); j++) begin
        n_vec++;
        if (j >= obs_o.size() || obs_o[j] != exp_o[j] || obs_b[j] != exp_b[j]) begin
          n_err++;
          $display("FAIL rand%0d_write%0d: owner=%0d byte=%h, required %0d/%h", round, j,
                   (j < obs_o.size()) ? obs_o[j] : -1, (j < obs_b.size()) ? obs_b[j] : -1, exp_o[j], exp_b[j]);
        end
      end
    end
  endtask

  initial begin
    bus_reset = 1'b0; req_valid = 4'h0; req_data = 32'h0; req_last = 4'h0; uart_ack = 1'b0;
    test_reset();
    test_single();
    test_locking();
    test_round_robin();
    test_timeout();
    test_stall();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Transmit-side arbiter and sequencer that shares the single `simpleuart` transmit data port between `NREQ` on-chip requesters (CPU console, debug dump, self-test banner, ...). It sits between the requesters and the UART's data-write port, drives the write strobe and data, and waits on the UART's write acknowledge. Each requester owns the UART for a whole message, from its first byte to the byte flagged `last`, so messages never interleave. Round-robin between messages, with an idle-lock timeout so a stalled owner cannot hold the UART forever.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 65535: consecutive idle `HOLD` cycles before the lock is forcibly released. 0 disables the timeout.

- `bus_clk`  in  1: the single clock; everything is synchronous to its rising edge.
- `bus_reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: requester i has a byte to send.
- `req_data`  in  8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_last`  in  NREQ: byte of requester i ends its message.
- `req_ready`  out  NREQ: one-cycle pulse, byte of requester i accepted by the UART.
- `grant`  out  NREQ: one-hot current owner; all zero when free.
- `busy`  out  1: state is not IDLE.
- `uart_we`  out  1: to the UART data-register write enable.
- `uart_di`  out  32: to the UART data-register write data, {24'd0, byte}.
- `uart_ack`  in  1: UART data-register write acknowledge.

## Operation
- States:
  - IDLE: no owner.
  - SEND: strobe held, waiting on `uart_ack`.
  - HOLD: owner keeps the lock between bytes.
- Registers:
  - `state`, `grant`.
  - `last_owner`, index, reset NREQ-1.
  - `byte_q` (8), `last_q` (1).
  - `idle_cnt`, width clog2(TIMEOUT+1).
- IDLE, any `req_valid`:
  - Pick the first set bit scanning from index (`last_owner`+1) mod NREQ upward with wrap.
  - `grant` <= one-hot of the winner.
  - `byte_q`/`last_q` <= the winner's data and last flag.
  - Next state SEND.
- IDLE with no valid: stay.
- SEND: `uart_we`=1, `uart_di`={24'd0,`byte_q`}; stay until `uart_ack`=1. On the ack cycle:
  - `req_ready`[owner]=1 (combinational: SEND & `uart_ack` & `grant`).
  - If `last_q`: `last_owner` <= owner, `grant` <= 0, next IDLE.
  - Else: `idle_cnt` <= 0, next HOLD.
- HOLD:
  - If `req_valid`[owner]: latch `byte_q`/`last_q`, next SEND.
  - Else if TIMEOUT!=0 and `idle_cnt`==TIMEOUT-1: release exactly as for `last`, next IDLE.
  - Else `idle_cnt` <= `idle_cnt`+1.
- Valid and timeout in the same HOLD cycle: valid wins, no release.
- Other requesters' `req_valid` is ignored while an owner holds the lock. It is never dropped; it is served at the next arbitration.
- Byte latched on entry to SEND: requester changes to `req_data`/`req_valid` during SEND do not alter the byte in flight, and `req_ready` still pulses on the ack.
- Requester rule: hold `req_valid`/`req_data` stable until `req_ready`. After the pulse, present the next byte no earlier than the following cycle.
- `uart_ack` outside SEND is ignored.

## Timing
- Reset values: `state`=IDLE, `grant`=0, `req_ready`=0, `uart_we`=0, `uart_di`=0, `busy`=0, `idle_cnt`=0, `last_owner`=NREQ-1.
- Valid in IDLE at cycle 0:
  - Cycle 1: `grant` set, `busy`=1, `uart_we`=1.
  - Ack at cycle k≥1 gives `req_ready` at cycle k.
- Same owner, next byte valid at k+1 (HOLD): `uart_we` again at k+2. One dead cycle per byte, ample at any baud.
- Message switch: the release cycle k is followed by IDLE at k+1, and the new `grant`/`uart_we` appear at k+2.
- `uart_we` is deasserted in the cycle after `uart_ack`. It is never asserted in IDLE or HOLD.
- Reset mid-SEND: outputs return to reset values the next cycle. No `req_ready` pulse, and the partial byte's fate is undefined; requesters are reset together.
- `grant` is always one-hot or zero. `req_ready` has at most one bit set.

## Test plan
- Single request: requester 2 sends 0x41 with last, ack 3 cycles after `uart_we` → one `uart_di`=0x41 write, `req_ready`=4'b0100 on the ack cycle, `grant` back to 0, `busy`=0 the next cycle.
- Message locking: requester 0 sends "AB" (last on B) while requester 1 holds 0x5A valid throughout → UART sees 0x41, 0x42, 0x5A in order. `grant` switches 0001→0000→0010.
- Round-robin: all four always valid, every byte last, immediate ack → grant order 0,1,2,3,0,1. Each grant is preceded by one IDLE cycle.
- Timeout: TIMEOUT=16; requester 3 sends 0x10 without last and then goes silent → release on the 16th HOLD cycle, after which requester 1's pending byte is granted. A valid arriving on exactly that 16th cycle keeps the lock.
- Stall plus disturbance: `uart_ack` held low for 1000 cycles with `req_data` changed mid-SEND → `uart_we` stays high with the original byte, and no `req_ready` until the ack.
- Reset mid-SEND: assert `bus_reset` for one cycle → all outputs at reset values the next cycle. Requester 0 is then granted first.
